// File: rtl/hazard_scoreboard_unit.sv
// Purpose : ID-stage hazard unit - EX/MEM/MD operand forwarding, load-use stall, MUL/DIV scoreboard.
// Latency : forwarding and stall are combinational; MD_DONE pulses MD_LAT cycles after MD_START.
// Backpr. : stalls PC/IF-ID and bubbles ID/EX on load-use or on a conflict with the outstanding MUL/DIV.
//
// Ports:
//   i_clk, i_rst_n                  clock (rising edge), synchronous active-low reset
//   i_addr1/2, i_use1/2             ID source registers and their read enables
//   i_idrd, i_idwe, i_idmd          ID destination, write enable, multi-cycle MUL/DIV flag
//   i_exrd, i_exwe, i_exmemr        EX destination, write enable, load flag
//   i_memrd, i_memwe                MEM destination, write enable
//   i_md_start, i_md_rd, i_flush    MUL/DIV entering EX, its destination, pipeline flush
//   o_fdata1sel/2sel                operand select: 00 regfile, 01 EX, 10 MEM, 11 MUL/DIV result
//   o_stall, o_bubble               hold PC/IF-ID, insert NOP into ID/EX (always equal)
//   o_md_busy, o_md_done            MUL/DIV outstanding, one-cycle result-at-writeback pulse
module hazard_scoreboard_unit #(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 34,
    parameter int CNT_W  = 6
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [REG_AW-1:0] i_addr1,
    input  logic [REG_AW-1:0] i_addr2,
    input  logic              i_use1,
    input  logic              i_use2,
    input  logic [REG_AW-1:0] i_idrd,
    input  logic              i_idwe,
    input  logic              i_idmd,
    input  logic [REG_AW-1:0] i_exrd,
    input  logic              i_exwe,
    input  logic              i_exmemr,
    input  logic [REG_AW-1:0] i_memrd,
    input  logic              i_memwe,
    input  logic              i_md_start,
    input  logic [REG_AW-1:0] i_md_rd,
    input  logic              i_flush,
    output logic [1:0]        o_fdata1sel,
    output logic [1:0]        o_fdata2sel,
    output logic              o_stall,
    output logic              o_bubble,
    output logic              o_md_busy,
    output logic              o_md_done
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LP_CNT_INIT = CNT_W'(MD_LAT - 1);
    localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [REG_AW-1:0] r_rd;
    logic              r_md_done;

    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [REG_AW-1:0] w_rd_nxt;
    logic              w_md_done_nxt;

    logic              w_busy;
    logic              w_load_use;
    logic              w_sb_stall;
    logic              w_rd_nz;

    // ------------------------------------------------------------------
    // Scoreboard FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_rd      <= '0;
            r_md_done <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rd      <= w_rd_nxt;
            r_md_done <= w_md_done_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard FSM: next state
    // The stored rd is kept through the done cycle so the dependent
    // instruction in ID can pick the result up via select 11.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_rd_nxt      = r_rd;
        w_md_done_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_md_start && !i_flush) begin
                    w_state_nxt = ST_BUSY;
                    w_cnt_nxt   = LP_CNT_INIT;
                    w_rd_nxt    = i_md_rd;
                end
            end
            ST_BUSY: begin
                if (i_flush) begin
                    // Cancelled op never reaches writeback: no done pulse.
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LP_CNT_ONE) begin
                    w_state_nxt   = ST_IDLE;
                    w_cnt_nxt     = '0;
                    w_md_done_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - LP_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_busy    = (r_state == ST_BUSY);
    assign w_rd_nz   = |r_rd;
    assign o_md_busy = w_busy;
    assign o_md_done = r_md_done;

    // ------------------------------------------------------------------
    // Forwarding select, priority EX > MEM > MD; x0 never forwards.
    // A load in EX has no data yet, so it is skipped here and the
    // load-use stall covers it.
    // ------------------------------------------------------------------
    function automatic logic [1:0] f_sel(input logic [REG_AW-1:0] addr,
                                         input logic              use_src);
        logic [1:0] sel;
        sel = 2'b00;
        if (use_src && (addr != '0)) begin
            if (i_exwe && (i_exrd == addr) && !i_exmemr) begin
                sel = 2'b01;
            end else if (i_memwe && (i_memrd == addr)) begin
                sel = 2'b10;
            end else if (r_md_done && (r_rd == addr)) begin
                sel = 2'b11;
            end
        end
        return sel;
    endfunction

    assign o_fdata1sel = f_sel(i_addr1, i_use1);
    assign o_fdata2sel = f_sel(i_addr2, i_use2);

    // ------------------------------------------------------------------
    // Stall sources
    // ------------------------------------------------------------------
    assign w_load_use = i_exmemr && i_exwe && (i_exrd != '0) &&
                        ((i_use1 && (i_exrd == i_addr1)) ||
                         (i_use2 && (i_exrd == i_addr2)));

    // A stored rd of x0 still occupies the unit, so only the structural
    // conflict applies to it.
    assign w_sb_stall = w_busy &&
                        (i_idmd ||
                         (w_rd_nz && ((i_use1 && (i_addr1 == r_rd)) ||
                                      (i_use2 && (i_addr2 == r_rd)) ||
                                      (i_idwe && (i_idrd  == r_rd)))));

    assign o_stall  = w_load_use || w_sb_stall;
    assign o_bubble = o_stall;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Purpose : self-checking bench for hazard_scoreboard_unit (directed + random, queue scoreboard).
// Latency : expectation for each cycle is pushed when inputs are driven, popped at the next falling edge.
// Backpr. : none; the monitor checks every cycle that the stimulus marks as checked.
module tb_hazard_scoreboard_unit;

    localparam int REG_AW = 5;
    localparam int MD_LAT = 34;
    localparam int CNT_W  = 6;

    typedef struct {
        logic [REG_AW-1:0] a1, a2, idrd, exrd, memrd, mdrd;
        logic u1, u2, idwe, idmd, exwe, exmemr, memwe, start, flush, rst_n;
    } in_t;

    typedef struct {
        int         cyc;
        logic [1:0] sel1, sel2;
        logic       stall, bubble, busy, done;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic [REG_AW-1:0] addr1, addr2, idrd, exrd, memrd, md_rd;
    logic              use1, use2, idwe, idmd, exwe, exmemr, memwe, md_start, flush;
    logic [1:0]        fdata1sel, fdata2sel;
    logic              stall, bubble, md_busy, md_done;

    hazard_scoreboard_unit #(.REG_AW(REG_AW), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_addr1    (addr1),
        .i_addr2    (addr2),
        .i_use1     (use1),
        .i_use2     (use2),
        .i_idrd     (idrd),
        .i_idwe     (idwe),
        .i_idmd     (idmd),
        .i_exrd     (exrd),
        .i_exwe     (exwe),
        .i_exmemr   (exmemr),
        .i_memrd    (memrd),
        .i_memwe    (memwe),
        .i_md_start (md_start),
        .i_md_rd    (md_rd),
        .i_flush    (flush),
        .o_fdata1sel(fdata1sel),
        .o_fdata2sel(fdata2sel),
        .o_stall    (stall),
        .o_bubble   (bubble),
        .o_md_busy  (md_busy),
        .o_md_done  (md_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    // Reference model: an accepted MUL/DIV started in cycle s is busy in
    // cycles s+1 .. s+MD_LAT-1 and delivers its result in cycle s+MD_LAT.
    int                m_cyc   = 0;
    bit                m_have  = 0;
    int                m_start = 0;
    logic [REG_AW-1:0] m_rd    = '0;

    function automatic bit m_busy();
        return m_have && (m_cyc > m_start) && (m_cyc < m_start + MD_LAT);
    endfunction

    function automatic bit m_done();
        return m_have && (m_cyc == m_start + MD_LAT);
    endfunction

    function automatic logic [1:0] m_sel(input in_t v, input logic [REG_AW-1:0] a, input logic u);
        if (!u || a == 0)                        return 2'd0;
        if (v.exwe && v.exrd == a && !v.exmemr)  return 2'd1;
        if (v.memwe && v.memrd == a)             return 2'd2;
        if (m_done() && m_rd == a)               return 2'd3;
        return 2'd0;
    endfunction

    function automatic exp_t m_expect(input in_t v);
        exp_t e;
        bit lu, sb, raw;
        lu  = v.exmemr && v.exwe && (v.exrd != 0) &&
              ((v.u1 && v.exrd == v.a1) || (v.u2 && v.exrd == v.a2));
        raw = (m_rd != 0) && ((v.u1 && v.a1 == m_rd) || (v.u2 && v.a2 == m_rd) ||
                              (v.idwe && v.idrd == m_rd));
        sb  = m_busy() && (v.idmd || raw);
        e.cyc    = m_cyc;
        e.sel1   = m_sel(v, v.a1, v.u1);
        e.sel2   = m_sel(v, v.a2, v.u2);
        e.stall  = lu || sb;
        e.bubble = lu || sb;
        e.busy   = m_busy();
        e.done   = m_done();
        return e;
    endfunction

    function automatic void m_step(input in_t v);
        if (!v.rst_n || v.flush) begin
            m_have = 0;
        end else if (v.start && !m_busy()) begin
            m_have  = 1;
            m_start = m_cyc;
            m_rd    = v.mdrd;
        end
        m_cyc++;
    endfunction

    function automatic in_t idle_in();
        in_t v;
        v = '{a1: '0, a2: '0, idrd: '0, exrd: '0, memrd: '0, mdrd: '0,
              u1: 0, u2: 0, idwe: 0, idmd: 0, exwe: 0, exmemr: 0, memwe: 0,
              start: 0, flush: 0, rst_n: 1};
        return v;
    endfunction

    // Drive one cycle of inputs, queue the expected response, advance the model.
    task automatic drive(input in_t v, input bit chk);
        addr1 = v.a1; addr2 = v.a2; use1 = v.u1; use2 = v.u2;
        idrd = v.idrd; idwe = v.idwe; idmd = v.idmd;
        exrd = v.exrd; exwe = v.exwe; exmemr = v.exmemr;
        memrd = v.memrd; memwe = v.memwe;
        md_start = v.start; md_rd = v.mdrd; flush = v.flush; rst_n = v.rst_n;
        if (chk) exp_q.push_back(m_expect(v));
        @(posedge clk);
        m_step(v);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive(idle_in(), 1'b1);
    endtask

    task automatic check(input string name, input int cyc, input int got, input int req);
        n_checks++;
        if (got != req) begin
            n_fails++;
            $display("FAIL %s cycle %0d: got %0d, required %0d", name, cyc, got, req);
        end
    endtask

    // Monitor: every queued expectation belongs to the cycle now in progress.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("fdata1sel", e.cyc, int'(fdata1sel), int'(e.sel1));
            check("fdata2sel", e.cyc, int'(fdata2sel), int'(e.sel2));
            check("stall",     e.cyc, int'(stall),     int'(e.stall));
            check("bubble",    e.cyc, int'(bubble),    int'(e.bubble));
            check("md_busy",   e.cyc, int'(md_busy),   int'(e.busy));
            check("md_done",   e.cyc, int'(md_done),   int'(e.done));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t v;

        // Reset: state is unknown before the first edge, so only check afterwards.
        v = idle_in(); v.rst_n = 0;
        drive(v, 1'b0);
        drive(v, 1'b1);
        idle_cycles(2);

        // Forwarding priority EX over MEM, then x0 never forwards.
        v = idle_in(); v.exrd = 5; v.memrd = 5; v.a1 = 5; v.exwe = 1; v.memwe = 1; v.u1 = 1;
        drive(v, 1'b1);
        v.a1 = 0;
        drive(v, 1'b1);

        // Load-use, then MEM forwarding resolves it.
        v = idle_in(); v.exmemr = 1; v.exwe = 1; v.exrd = 7; v.a2 = 7; v.u2 = 1;
        drive(v, 1'b1);
        v = idle_in(); v.memrd = 7; v.memwe = 1; v.a2 = 7; v.u2 = 1;
        drive(v, 1'b1);

        // Full MUL/DIV latency with a dependent instruction held in ID.
        v = idle_in(); v.start = 1; v.mdrd = 9;
        drive(v, 1'b1);
        v = idle_in(); v.a1 = 9; v.u1 = 1;
        for (int i = 0; i < MD_LAT + 2; i++) drive(v, 1'b1);

        // Structural, WAW and unrelated instructions while busy, then flush.
        v = idle_in(); v.start = 1; v.mdrd = 9;
        drive(v, 1'b1);
        v = idle_in(); v.idmd = 1;
        drive(v, 1'b1);
        v = idle_in(); v.idwe = 1; v.idrd = 9;
        drive(v, 1'b1);
        v = idle_in(); v.a1 = 3; v.u1 = 1; v.idwe = 1; v.idrd = 4;
        drive(v, 1'b1);
        idle_cycles(20);
        v = idle_in(); v.flush = 1;
        drive(v, 1'b1);
        idle_cycles(MD_LAT);

        // Flush together with start does not start.
        v = idle_in(); v.start = 1; v.flush = 1; v.mdrd = 6;
        drive(v, 1'b1);
        idle_cycles(3);

        // Reset while busy, then a fresh op runs its full latency.
        v = idle_in(); v.start = 1; v.mdrd = 12;
        drive(v, 1'b1);
        idle_cycles(5);
        v = idle_in(); v.rst_n = 0; v.start = 1; v.mdrd = 13;
        drive(v, 1'b1);
        v = idle_in(); v.start = 1; v.mdrd = 12;
        drive(v, 1'b1);
        v = idle_in(); v.a2 = 12; v.u2 = 1;
        for (int i = 0; i < MD_LAT + 2; i++) drive(v, 1'b1);

        // Random traffic over a small register window to provoke collisions.
        for (int i = 0; i < 3000; i++) begin
            v.a1     = REG_AW'($urandom_range(0, 7));
            v.a2     = REG_AW'($urandom_range(0, 7));
            v.idrd   = REG_AW'($urandom_range(0, 7));
            v.exrd   = REG_AW'($urandom_range(0, 7));
            v.memrd  = REG_AW'($urandom_range(0, 7));
            v.mdrd   = REG_AW'($urandom_range(0, 7));
            v.u1     = 1'($urandom);
            v.u2     = 1'($urandom);
            v.idwe   = 1'($urandom);
            v.idmd   = ($urandom_range(0, 3) == 0);
            v.exwe   = 1'($urandom);
            v.exmemr = ($urandom_range(0, 2) == 0);
            v.memwe  = 1'($urandom);
            v.start  = ($urandom_range(0, 5) == 0);
            v.flush  = ($urandom_range(0, 40) == 0);
            v.rst_n  = ($urandom_range(0, 200) != 0);
            drive(v, 1'b1);
        end

        idle_cycles(1);
        @(negedge clk);
        #1;
        check("queue_drained", m_cyc, exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
